pipe_stage_reg: RTL and testbench

- Parametrised pipeline boundary register for fetch→decode and later stage boundaries; successor to the fixed IF/DC latch.
- Carries next-PC, instruction word and generic sideband with a valid/ready handshake instead of a bare enable.
- Flush inserts a bubble (NOP, valid low).
- Optional skid mode registers the input-side ready so backpressure does not form a combinational path across stages.

---
 rtl/pipe_stage_reg_pkg.sv | 17 +
 rtl/pipe_stage_reg_if.sv | 33 +++
 rtl/pipe_stage_reg_sat_counter.sv | 38 +++
 rtl/pipe_stage_reg.sv | 169 ++++++++++++++++
 tb/tb_pipe_stage_reg.sv | 245 ++++++++++++++++++++++++
 5 files changed

// File: rtl/pipe_stage_reg_pkg.sv
// pipe_stage_reg_pkg: shared CPU pipeline types for the stage-boundary registers.
//   word_t       - default machine word (sets the default WORD_W)
//   pipe_state_t - occupancy of a skid-buffered stage {PS_EMPTY, PS_BUSY, PS_FULL}
//   NOP_INSTR    - instruction word presented while a bubble is held
package pipe_stage_reg_pkg;

    typedef logic [31:0] word_t;

    typedef enum logic [1:0] {
        PS_EMPTY,
        PS_BUSY,
        PS_FULL
    } pipe_state_t;

    localparam word_t NOP_INSTR = '0;

endpackage

// File: rtl/pipe_stage_reg_if.sv
// pipe_stage_reg_if: all handshake/payload signals of one pipeline boundary.
//   master modport - upstream stage + downstream consumer + hazard unit side
//   slave  modport - the boundary register itself
// Signals: in_valid/in_ready/in_npc/in_instr/in_side (upstream), flush,
//          out_valid/out_ready/out_npc/out_instr/out_side (downstream).
interface pipe_stage_reg_if #(
    parameter int unsigned WORD_W = 32,
    parameter int unsigned SIDE_W = 8
);

    logic              in_valid;
    logic              in_ready;
    logic [WORD_W-1:0] in_npc;
    logic [WORD_W-1:0] in_instr;
    logic [SIDE_W-1:0] in_side;
    logic              flush;
    logic              out_valid;
    logic              out_ready;
    logic [WORD_W-1:0] out_npc;
    logic [WORD_W-1:0] out_instr;
    logic [SIDE_W-1:0] out_side;

    modport master (
        output in_valid, in_npc, in_instr, in_side, flush, out_ready,
        input  in_ready, out_valid, out_npc, out_instr, out_side
    );

    modport slave (
        input  in_valid, in_npc, in_instr, in_side, flush, out_ready,
        output in_ready, out_valid, out_npc, out_instr, out_side
    );

endinterface

// File: rtl/pipe_stage_reg_sat_counter.sv
// pipe_stage_reg_sat_counter: event counter that sticks at all-ones.
//   CLK, nRST (async, active-low) - clock / reset to zero
//   inc_i   - count one event this cycle
//   clear_i - synchronous clear (wins over inc_i)
//   cnt_o   - current count
module pipe_stage_reg_sat_counter #(
    parameter int unsigned W = 32
) (
    input  logic         CLK,
    input  logic         nRST,
    input  logic         inc_i,
    input  logic         clear_i,
    output logic [W-1:0] cnt_o
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (inc_i && (cnt_q != '1)) begin
            cnt_d = cnt_q + W'(1);
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: pipeline boundary register (npc, instruction, sideband)
// with valid/ready handshake and flush-to-bubble.
//   CLK  - clock, rising edge
//   nRST - asynchronous active-low reset; empties the stage
//   bus  - pipe_stage_reg_if.slave: in_* upstream side, out_* downstream
//          side, flush from the hazard unit
//   SKID = 0: single register, in_ready = out_ready | ~out_valid
//   SKID = 1: main + one-entry skid register, in_ready decoded from state
// Optional build macro PIPE_STAGE_STATS_EN adds stall_cnt / flush_cnt
// (32-bit saturating) output ports.
module pipe_stage_reg
    import pipe_stage_reg_pkg::*;
#(
    parameter int unsigned WORD_W = $bits(word_t),
    parameter int unsigned SIDE_W = 8,
    parameter int unsigned SKID   = 1
) (
    input  logic CLK,
    input  logic nRST,
    pipe_stage_reg_if.slave bus
`ifdef PIPE_STAGE_STATS_EN
    ,
    output logic [31:0] stall_cnt,
    output logic [31:0] flush_cnt
`endif
);

    typedef struct packed {
        logic [WORD_W-1:0] npc;
        logic [WORD_W-1:0] instr;
        logic [SIDE_W-1:0] side;
    } stage_t;

    localparam logic [WORD_W-1:0] NOP_W = WORD_W'(NOP_INSTR);

    stage_t in_pl;
    stage_t main_w;
    logic   valid_w;
    logic   in_ready_w;

    assign in_pl = '{npc: bus.in_npc, instr: bus.in_instr, side: bus.in_side};

    if (SKID == 0) begin : g_noskid

        logic   valid_q, valid_d;
        stage_t main_q, main_d;

        assign in_ready_w = bus.out_ready | ~valid_q;

        always_comb begin
            valid_d = valid_q;
            main_d  = main_q;
            if (bus.flush) begin
                // npc/side keep their old values; only the instruction is squashed
                valid_d      = 1'b0;
                main_d.instr = NOP_W;
            end else if (bus.in_valid && in_ready_w) begin
                valid_d = 1'b1;
                main_d  = in_pl;
            end else if (valid_q && bus.out_ready) begin
                valid_d = 1'b0;
            end
        end

        always_ff @(posedge CLK or negedge nRST) begin
            if (!nRST) begin
                valid_q <= 1'b0;
                main_q  <= '0;
            end else begin
                valid_q <= valid_d;
                main_q  <= main_d;
            end
        end

        assign valid_w = valid_q;
        assign main_w  = main_q;

    end else begin : g_skid

        pipe_state_t state_q, state_d;
        stage_t      main_q, main_d;
        stage_t      skid_q, skid_d;

        // Ready comes straight from the state flop, so downstream out_ready
        // never reaches upstream combinationally.
        assign in_ready_w = (state_q != PS_FULL);

        always_comb begin
            state_d = state_q;
            main_d  = main_q;
            skid_d  = skid_q;
            if (bus.flush) begin
                state_d      = PS_EMPTY;
                main_d.instr = NOP_W;
                skid_d       = '0;
            end else begin
                unique case (state_q)
                    PS_EMPTY: begin
                        if (bus.in_valid) begin
                            state_d = PS_BUSY;
                            main_d  = in_pl;
                        end
                    end
                    PS_BUSY: begin
                        if (bus.in_valid && bus.out_ready) begin
                            main_d = in_pl;
                        end else if (bus.in_valid) begin
                            state_d = PS_FULL;
                            skid_d  = in_pl;
                        end else if (bus.out_ready) begin
                            state_d = PS_EMPTY;
                        end
                    end
                    PS_FULL: begin
                        if (bus.out_ready) begin
                            state_d = PS_BUSY;
                            main_d  = skid_q;
                            skid_d  = '0;
                        end
                    end
                    default: state_d = PS_EMPTY;
                endcase
            end
        end

        always_ff @(posedge CLK or negedge nRST) begin
            if (!nRST) begin
                state_q <= PS_EMPTY;
                main_q  <= '0;
                skid_q  <= '0;
            end else begin
                state_q <= state_d;
                main_q  <= main_d;
                skid_q  <= skid_d;
            end
        end

        assign valid_w = (state_q != PS_EMPTY);
        assign main_w  = main_q;

    end

    assign bus.in_ready  = in_ready_w;
    assign bus.out_valid = valid_w;
    assign bus.out_npc   = main_w.npc;
    assign bus.out_instr = main_w.instr;
    assign bus.out_side  = main_w.side;

`ifdef PIPE_STAGE_STATS_EN
    // An occupied skid always implies out_valid, so out_valid alone
    // covers "stage holds something" for the flush counter.
    pipe_stage_reg_sat_counter #(.W(32)) u_stall_cnt (
        .CLK     (CLK),
        .nRST    (nRST),
        .inc_i   (valid_w & ~bus.out_ready),
        .clear_i (1'b0),
        .cnt_o   (stall_cnt)
    );

    pipe_stage_reg_sat_counter #(.W(32)) u_flush_cnt (
        .CLK     (CLK),
        .nRST    (nRST),
        .inc_i   (bus.flush & valid_w),
        .clear_i (1'b0),
        .cnt_o   (flush_cnt)
    );
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb_pipe_stage_reg: directed bench for pipe_stage_reg.
//   dut0 - SKID=0 instance, dut1 - SKID=1 instance, each on its own interface.
// Stats counters are checked when PIPE_STAGE_STATS_EN is defined.
module tb_pipe_stage_reg;

    logic CLK;
    logic nRST;
    int   n_tests;
    int   n_fail;

    pipe_stage_reg_if #(.WORD_W(32), .SIDE_W(8)) if0 ();
    pipe_stage_reg_if #(.WORD_W(32), .SIDE_W(8)) if1 ();

`ifdef PIPE_STAGE_STATS_EN
    logic [31:0] stall0, flush0, stall1, flush1;
`endif

    pipe_stage_reg #(.WORD_W(32), .SIDE_W(8), .SKID(0)) dut0 (
        .CLK  (CLK),
        .nRST (nRST),
        .bus  (if0)
`ifdef PIPE_STAGE_STATS_EN
        ,
        .stall_cnt (stall0),
        .flush_cnt (flush0)
`endif
    );

    pipe_stage_reg #(.WORD_W(32), .SIDE_W(8), .SKID(1)) dut1 (
        .CLK  (CLK),
        .nRST (nRST),
        .bus  (if1)
`ifdef PIPE_STAGE_STATS_EN
        ,
        .stall_cnt (stall1),
        .flush_cnt (flush1)
`endif
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    typedef struct {
        logic        iv;
        logic [31:0] npc;
        logic [31:0] instr;
        logic [7:0]  side;
        logic        fl;
        logic        ordy;
        logic        e_rdy;
        logic        e_vld;
        logic [31:0] e_npc;
        logic [31:0] e_instr;
        logic [7:0]  e_side;
    } vec_t;

    function automatic vec_t mk(input logic iv, input logic [31:0] npc,
                                input logic [31:0] instr, input logic [7:0] side,
                                input logic fl, input logic ordy, input logic e_rdy,
                                input logic e_vld, input logic [31:0] e_npc,
                                input logic [31:0] e_instr, input logic [7:0] e_side);
        vec_t v;
        v.iv = iv; v.npc = npc; v.instr = instr; v.side = side;
        v.fl = fl; v.ordy = ordy; v.e_rdy = e_rdy; v.e_vld = e_vld;
        v.e_npc = e_npc; v.e_instr = e_instr; v.e_side = e_side;
        return v;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    vec_t      vt[15];
    logic [31:0] q[$];
    logic      mvalid;
    logic      ordy;
    logic      iv;
    logic      exp_rdy;
    logic [1:0] pat[4];
    int        n_acc;
    int        n_del;

    initial begin
        n_tests = 0;
        n_fail  = 0;

        //       iv  npc           instr          side   fl ordy rdy vld e_npc         e_instr        e_side
        vt[0]  = mk(1, 32'h4,  32'h8C410000, 8'h01, 0, 1, 1, 1, 32'h4,  32'h8C410000, 8'h01);
        vt[1]  = mk(0, 32'h0,  32'h0,        8'h00, 0, 1, 1, 0, 32'h4,  32'h8C410000, 8'h01);
        vt[2]  = mk(1, 32'hA,  32'hAAAA,     8'h0A, 0, 0, 1, 1, 32'hA,  32'hAAAA,     8'h0A);
        vt[3]  = mk(1, 32'hB,  32'hBBBB,     8'h0B, 0, 0, 1, 1, 32'hA,  32'hAAAA,     8'h0A);
        vt[4]  = mk(0, 32'h0,  32'h0,        8'h00, 0, 0, 0, 1, 32'hA,  32'hAAAA,     8'h0A);
        vt[5]  = mk(0, 32'h0,  32'h0,        8'h00, 0, 1, 0, 1, 32'hB,  32'hBBBB,     8'h0B);
        vt[6]  = mk(0, 32'h0,  32'h0,        8'h00, 0, 1, 1, 0, 32'hB,  32'hBBBB,     8'h0B);
        vt[7]  = mk(1, 32'h10, 32'h1010,     8'h10, 0, 0, 1, 1, 32'h10, 32'h1010,     8'h10);
        vt[8]  = mk(1, 32'h14, 32'h1414,     8'h14, 0, 0, 1, 1, 32'h10, 32'h1010,     8'h10);
        vt[9]  = mk(1, 32'h18, 32'h1818,     8'h18, 1, 0, 0, 0, 32'h10, 32'h0,        8'h10);
        vt[10] = mk(0, 32'h0,  32'h0,        8'h00, 0, 1, 1, 0, 32'h10, 32'h0,        8'h10);
        vt[11] = mk(1, 32'h20, 32'h2020,     8'h20, 0, 1, 1, 1, 32'h20, 32'h2020,     8'h20);
        vt[12] = mk(0, 32'h0,  32'h0,        8'h00, 1, 1, 1, 0, 32'h20, 32'h0,        8'h20);
        vt[13] = mk(1, 32'h24, 32'h2424,     8'h24, 0, 1, 1, 1, 32'h24, 32'h2424,     8'h24);
        vt[14] = mk(1, 32'h28, 32'h2828,     8'h28, 0, 1, 1, 1, 32'h28, 32'h2828,     8'h28);

        pat[0] = 2'd1; pat[1] = 2'd0; pat[2] = 2'd0; pat[3] = 2'd1;

        nRST = 1'b0;
        if0.in_valid = 1'b0; if0.in_npc = '0; if0.in_instr = '0; if0.in_side = '0;
        if0.flush = 1'b0; if0.out_ready = 1'b0;
        if1.in_valid = 1'b0; if1.in_npc = '0; if1.in_instr = '0; if1.in_side = '0;
        if1.flush = 1'b0; if1.out_ready = 1'b0;
        repeat (2) @(negedge CLK);
        nRST = 1'b1;
        #1;

        chk("rst0 out_valid", if0.out_valid, 0);
        chk("rst0 out_instr", if0.out_instr, 0);
        chk("rst0 in_ready",  if0.in_ready, 1);
        chk("rst1 out_valid", if1.out_valid, 0);
        chk("rst1 out_npc",   if1.out_npc, 0);
        chk("rst1 out_instr", if1.out_instr, 0);
        chk("rst1 out_side",  if1.out_side, 0);
        chk("rst1 in_ready",  if1.in_ready, 1);

        // SKID=1 table
        for (int i = 0; i < 15; i++) begin
            @(negedge CLK);
            if1.in_valid  = vt[i].iv;
            if1.in_npc    = vt[i].npc;
            if1.in_instr  = vt[i].instr;
            if1.in_side   = vt[i].side;
            if1.flush     = vt[i].fl;
            if1.out_ready = vt[i].ordy;
            #1;
            chk($sformatf("vec%0d in_ready", i), if1.in_ready, vt[i].e_rdy);
            @(posedge CLK);
            #1;
            chk($sformatf("vec%0d out_valid", i), if1.out_valid, vt[i].e_vld);
            chk($sformatf("vec%0d out_npc", i),   if1.out_npc,   vt[i].e_npc);
            chk($sformatf("vec%0d out_instr", i), if1.out_instr, vt[i].e_instr);
            chk($sformatf("vec%0d out_side", i),  if1.out_side,  vt[i].e_side);
        end
        @(negedge CLK);
        if1.in_valid = 1'b0; if1.flush = 1'b0; if1.out_ready = 1'b0;

        // SKID=0 scoreboard with out_ready pattern 1,0,0,1 and continuous in_valid
        mvalid = 1'b0;
        n_acc  = 0;
        n_del  = 0;
        for (int c = 0; c < 18; c++) begin
            if (c != 0) @(negedge CLK);
            iv   = (c < 16);
            ordy = (c < 16) ? pat[c % 4][0] : 1'b1;
            if0.in_valid  = iv;
            if0.in_npc    = 32'h100 + 32'(c);
            if0.in_instr  = 32'h5000 + 32'(c);
            if0.in_side   = 8'(c);
            if0.out_ready = ordy;
            #1;
            exp_rdy = ordy | ~mvalid;
            chk($sformatf("sb%0d in_ready", c), if0.in_ready, exp_rdy);
            if (if0.out_valid && ordy) begin
                n_del++;
                if (q.size() == 0) begin
                    chk($sformatf("sb%0d spurious beat", c), if0.out_npc, 0);
                end else begin
                    chk($sformatf("sb%0d out_npc", c), if0.out_npc, q.pop_front());
                end
            end
            if (iv && exp_rdy) begin
                q.push_back(32'h100 + 32'(c));
                n_acc++;
                mvalid = 1'b1;
            end else if (mvalid && ordy) begin
                mvalid = 1'b0;
            end
            @(posedge CLK);
            #1;
            chk($sformatf("sb%0d out_valid", c), if0.out_valid, mvalid);
        end
        chk("sb queue empty", q.size(), 0);
        chk("sb delivered", n_del, n_acc);
        @(negedge CLK);
        if0.in_valid = 1'b0; if0.out_ready = 1'b0;

        // Async reset mid-operation on SKID=1: fill main + skid, then pulse nRST
        if1.in_valid = 1'b1; if1.in_npc = 32'h55; if1.in_instr = 32'h5555; if1.in_side = 8'h55;
        if1.out_ready = 1'b0;
        @(posedge CLK);
        #1;
        chk("arst pre out_valid", if1.out_valid, 1);
        chk("arst pre in_ready", if1.in_ready, 0);
        #2;
        nRST = 1'b0;
        #1;
        chk("arst out_valid", if1.out_valid, 0);
        chk("arst out_npc",   if1.out_npc, 0);
        chk("arst out_instr", if1.out_instr, 0);
        chk("arst out_side",  if1.out_side, 0);
        chk("arst in_ready",  if1.in_ready, 1);
`ifdef PIPE_STAGE_STATS_EN
        chk("arst stall_cnt", stall1, 0);
        chk("arst flush_cnt", flush1, 0);
`endif
        @(negedge CLK);
        nRST = 1'b1;
        if1.in_valid = 1'b0; if1.out_ready = 1'b1;
        @(posedge CLK);
        #1;
        chk("arst post out_valid", if1.out_valid, 0);

`ifdef PIPE_STAGE_STATS_EN
        @(negedge CLK);
        if1.in_valid = 1'b1; if1.in_npc = 32'h60; if1.out_ready = 1'b0;
        @(negedge CLK);
        if1.in_valid = 1'b0;
        repeat (5) @(negedge CLK);
        if1.flush = 1'b1; if1.out_ready = 1'b1;
        @(posedge CLK);
        #1;
        chk("stats stall_cnt", stall1, 5);
        chk("stats flush_cnt", flush1, 1);
        chk("stats flushed out_valid", if1.out_valid, 0);
        @(negedge CLK);
        @(posedge CLK);
        #1;
        chk("stats flush idle", flush1, 1);
        chk("stats dut0 stall_cnt", stall0, 0);
        if1.flush = 1'b0;
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
